// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave register file with independent AW/W capture, WSTRB byte enables and SLVERR decode.
// Optional AXIL_REGFILE_PROT_EN adds AWPROT/ARPROT and blocks unprivileged access to the upper half.
module axil_regfile_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
`ifdef AXIL_REGFILE_PROT_EN
  input  logic [2:0]              AWPROT,
`endif
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
`ifdef AXIL_REGFILE_PROT_EN
  input  logic [2:0]              ARPROT,
`endif
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned HI     = LSB + IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_ok, rd_ok;

`ifdef AXIL_REGFILE_PROT_EN
  logic awpriv_q;
  logic wr_priv;
  logic unused_prot;
  assign unused_prot = ^{AWPROT[2:1], ARPROT[2:1]};
`endif

  assign AWREADY = ARESETN && !aw_held_q && !bvalid_q;
  assign WREADY  = ARESETN && !w_held_q && !bvalid_q;
  assign ARREADY = ARESETN && !rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  // Commit happens on the edge where the second of AW/W arrives, so hold regs are bypassed.
  always_comb begin
    aw_hs   = AWVALID && AWREADY;
    w_hs    = WVALID && WREADY;
    ar_hs   = ARVALID && ARREADY;
    commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    wr_addr = aw_held_q ? awaddr_q : AWADDR;
    wr_data = w_held_q ? wdata_q : WDATA;
    wr_strb = w_held_q ? wstrb_q : WSTRB;
    wr_idx  = wr_addr[LSB +: IDX_W];
    rd_idx  = ARADDR[LSB +: IDX_W];
    wr_ok   = (wr_addr >> HI) == '0;
    rd_ok   = (ARADDR >> HI) == '0;
`ifdef AXIL_REGFILE_PROT_EN
    wr_priv = aw_held_q ? awpriv_q : AWPROT[0];
    if (!wr_priv && wr_idx[IDX_W-1]) wr_ok = 1'b0;
    if (!ARPROT[0] && rd_idx[IDX_W-1]) rd_ok = 1'b0;
`endif
  end

  // Sub-word address bits are deliberately ignored.
  logic unused_lsbs;
  assign unused_lsbs = ^{wr_addr[LSB-1:0], ARADDR[LSB-1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
`ifdef AXIL_REGFILE_PROT_EN
      awpriv_q  <= 1'b0;
`endif
    end else begin
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= AWADDR;
`ifdef AXIL_REGFILE_PROT_EN
          awpriv_q  <= AWPROT[0];
`endif
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= WDATA;
          wstrb_q  <= WSTRB;
        end
        if (bvalid_q && BREADY) bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Register array is read with pre-commit contents when AR and a write land on one edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= rd_ok ? regs_q[rd_idx] : '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed self-checking bench for axil_regfile_slave (default build, 32-bit data, 32 registers).
module tb_axil_regfile_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  axil_regfile_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .NUM_REGS  (32)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .AWADDR (AWADDR),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done;
    int   n;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n       = 0;
    AWADDR  = addr;
    WDATA   = data;
    WSTRB   = strb;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (AWVALID && AWREADY) aw_done = 1'b1;
      if (WVALID && WREADY) w_done = 1'b1;
      tick();
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
      n++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("wr_handshake_done", {31'd0, aw_done && w_done}, 32'd1);
    check("wr_bvalid_latency", {31'd0, BVALID}, 32'd1);
    resp   = BRESP;
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("wr_bvalid_clear", {31'd0, BVALID}, 32'd0);
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
    int n;
    n       = 0;
    ARADDR  = addr;
    ARVALID = 1'b1;
    while (!ARREADY && n < 20) begin
      tick();
      n++;
    end
    check("rd_arready_seen", {31'd0, ARREADY}, 32'd1);
    tick();
    ARVALID = 1'b0;
    check("rd_rvalid_latency", {31'd0, RVALID}, 32'd1);
    data   = RDATA;
    resp   = RRESP;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rd_rvalid_clear", {31'd0, RVALID}, 32'd0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;

  initial begin
    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    tick();
    tick();
    check("rst_awready", {31'd0, AWREADY}, 32'd0);
    check("rst_wready", {31'd0, WREADY}, 32'd0);
    check("rst_arready", {31'd0, ARREADY}, 32'd0);
    check("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_rvalid", {31'd0, RVALID}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    ARESETN = 1'b1;
    tick();
    check("post_rst_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

    // 1: same-cycle AW/W; B on the next cycle; readback
    axil_write(32'h14, 32'hA5A5_A5A5, 4'hF, rsp);
    check("t1_bresp", {30'd0, rsp}, 32'd0);
    axil_read(32'h14, rd, rsp);
    check("t1_rdata", rd, 32'hA5A5_A5A5);
    check("t1_rresp", {30'd0, rsp}, 32'd0);
    axil_read(32'h17, rd, rsp);
    check("t1_misaligned_rdata", rd, 32'hA5A5_A5A5);

    // 2: W three cycles ahead of AW, BREADY held low 4 cycles
    WDATA = 32'h1234_5678; WSTRB = 4'hF; WVALID = 1'b1;
    check("t2_wready_pre", {31'd0, WREADY}, 32'd1);
    tick();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_held", {31'd0, WREADY}, 32'd0);
      check("t2_awready_open", {31'd0, AWREADY}, 32'd1);
      check("t2_no_bvalid", {31'd0, BVALID}, 32'd0);
      if (i < 2) tick();
    end
    AWADDR = 32'h28; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("t2_bvalid", {31'd0, BVALID}, 32'd1);
    check("t2_bresp", {30'd0, BRESP}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t2_awready_blocked", {31'd0, AWREADY}, 32'd0);
      check("t2_wready_blocked", {31'd0, WREADY}, 32'd0);
      check("t2_bvalid_hold", {31'd0, BVALID}, 32'd1);
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("t2_bvalid_clear", {31'd0, BVALID}, 32'd0);
    check("t2_awready_back", {31'd0, AWREADY}, 32'd1);
    axil_read(32'h28, rd, rsp);
    check("t2_rdata", rd, 32'h1234_5678);

    // 3: byte strobes
    axil_write(32'h08, 32'hFFFF_FFFF, 4'hF, rsp);
    axil_write(32'h08, 32'h0000_0000, 4'b0101, rsp);
    axil_read(32'h08, rd, rsp);
    check("t3_rdata", rd, 32'hFF00_FF00);
    axil_write(32'h08, 32'h0000_0000, 4'b0000, rsp);
    check("t3_zero_strb_bresp", {30'd0, rsp}, 32'd0);
    axil_read(32'h08, rd, rsp);
    check("t3_zero_strb_rdata", rd, 32'hFF00_FF00);

    // 4: out-of-range write/read; 0xA0 would alias index 8 (0x20) if decode were truncated
    axil_write(32'hA0, 32'hDEAD_BEEF, 4'hF, rsp);
    check("t4_bresp", {30'd0, rsp}, 32'd2);
    axil_read(32'h20, rd, rsp);
    check("t4_alias_rdata", rd, 32'd0);
    axil_read(32'hA0, rd, rsp);
    check("t4_oor_rdata", rd, 32'd0);
    check("t4_oor_rresp", {30'd0, rsp}, 32'd2);
    axil_read(32'h3C, rd, rsp);
    check("t4_unwritten_rdata", rd, 32'd0);
    check("t4_unwritten_rresp", {30'd0, rsp}, 32'd0);
    axil_read(32'h8000_0000, rd, rsp);
    check("t4_topbit_rresp", {30'd0, rsp}, 32'd2);

    // 5: read and write commit to the same index on one edge
    axil_write(32'h0C, 32'h1111_1111, 4'hF, rsp);
    AWADDR = 32'h0C; WDATA = 32'h8765_4321; WSTRB = 4'hF; ARADDR = 32'h0C;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    check("t5_all_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("t5_rvalid", {31'd0, RVALID}, 32'd1);
    check("t5_rdata_old", RDATA, 32'h1111_1111);
    check("t5_bvalid", {31'd0, BVALID}, 32'd1);
    RREADY = 1'b1; BREADY = 1'b1;
    tick();
    RREADY = 1'b0; BREADY = 1'b0;
    axil_read(32'h0C, rd, rsp);
    check("t5_rdata_new", rd, 32'h8765_4321);

    // 6: reset with AW held and W pending
    AWADDR = 32'h30; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("t6_aw_held", {31'd0, AWREADY}, 32'd0);
    WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WVALID = 1'b1;
    ARESETN = 1'b0;
    #1;
    check("t6_rst_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
    check("t6_rst_bvalid", {31'd0, BVALID}, 32'd0);
    tick();
    check("t6_rst_ready_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
    check("t6_rst_bvalid_edge", {31'd0, BVALID}, 32'd0);
    WVALID  = 1'b0;
    ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_bresp", {31'd0, BVALID}, 32'd0);
    end
    check("t6_ready_after", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
    axil_read(32'h30, rd, rsp);
    check("t6_rdata", rd, 32'd0);
    axil_read(32'h14, rd, rsp);
    check("t6_cleared_other", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
Parametrised AXI4-Lite slave register file that replaces the fixed read_s/write_s register block under axi4_lite_top.
- Full five-channel AXI4-Lite handshakes.
- Independent AW/W acceptance and WSTRB byte enables.
- Configurable register count, and SLVERR responses for out-of-range accesses.

Parameters:
DATA_WIDTH, 32, data bus width; 32 or 64 only.
ADDR_WIDTH, 32, AWADDR/ARADDR width.
NUM_REGS, 32, number of registers; power of 2, 2..256.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESETN  in  1  asynchronous active-low reset.
AWADDR  in  ADDR_WIDTH  write address (byte address).
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte enables.
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
BVALID  out  1  write response valid.
BREADY  in  1  write response ready.
ARADDR  in  ADDR_WIDTH  read address (byte address).
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
RVALID  out  1  read data valid.
RREADY  in  1  read data ready.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All registers clear to 0.
  - BVALID, RVALID, BRESP, RRESP and RDATA clear to 0.
  - AW/W/AR holding flags clear.
  - All READY outputs are 0 while ARESETN is low.
- Reset mid-transaction drops all in-flight state. No response is issued for it after release.
- Decode:
  - LSB = log2(DATA_WIDTH/8); the register index is addr[LSB +: log2(NUM_REGS)].
  - Address bits below LSB are ignored, so misaligned addresses are silently aligned.
  - Any set address bit above the index field makes the access out of range.
- Write path:
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - On handshake, AWADDR and WDATA/WSTRB are captured into their holding registers and the held flag is set.
  - AW and W may complete in either order or in the same cycle.
  - Commit edge: the first rising edge on which both are held. At that edge:
    - In range: each byte lane with WSTRB=1 is updated; other lanes keep their value. BRESP=00.
    - Out of range: no register changes. BRESP=10.
    - BVALID rises and both held flags clear.
  - If the AW and W handshakes are in the same cycle, BVALID is high on the next cycle.
  - BVALID holds, with BRESP stable, until a BVALID&&BREADY edge.
  - No new AW/W is accepted while BVALID=1. Maximum one outstanding write.
- Read path:
  - ARREADY = !RVALID.
  - On an ARVALID&&ARREADY edge:
    - RVALID rises.
    - In range: RDATA is the register value sampled at that edge, RRESP=00.
    - Out of range: RDATA=0, RRESP=10.
  - RDATA/RRESP stay stable until RVALID&&RREADY; RVALID then clears.
  - Read latency is 1 cycle from AR handshake to RVALID. Throughput is one read per 2 cycles.
- Simultaneous events:
  - Read and write paths are fully independent.
  - If the AR handshake and a write commit to the same index fall on the same edge, the read returns the pre-write value.
- WSTRB=0 to a valid address: no change, BRESP=00.

Optional Feature:
AXIL_REGFILE_PROT_EN
- Defined:
  - Adds inputs AWPROT[2:0] and ARPROT[2:0], captured with their address.
  - An access with PROT[0]=0 (unprivileged) to index >= NUM_REGS/2 is treated as out of range: SLVERR, no write, RDATA=0.
  - Privileged accesses behave normally.
- Not defined: ports absent; all in-range accesses return OKAY.

Test Plan:
1. Reset, then AW(0x14) and W(0xA5A5A5A5, WSTRB=F) in the same cycle -> BVALID on the next cycle, BRESP=00. AR(0x14) -> RVALID one cycle after AR handshake, RDATA=A5A5A5A5, RRESP=00.
2. W(0x12345678) given 3 cycles before AW(0x28), with BREADY held low 4 cycles -> WREADY low after W capture, AWREADY=1 until the AW handshake, then low while BVALID=1. BVALID stays high until BREADY. Readback at 0x28 = 12345678.
3. Write 0xFFFFFFFF to 0x08, then write 0x00000000 with WSTRB=0101 -> readback 0xFF00FF00.
4. Write 0xDEADBEEF to 0xA0 (index 40 >= 32) -> BRESP=10 and no register changed. Read 0xA0 -> RDATA=0, RRESP=10. Read of an unwritten in-range 0x3C -> RDATA=0, RRESP=00.
5. AR(0x0C) on the same edge as a write commit of 0x87654321 to 0x0C (old value 0x11111111) -> RDATA=11111111. A following read -> 87654321.
6. Assert ARESETN low with AW held and W pending -> BVALID=0 and all READYs 0 during reset. After release, no B response appears and readback of the target register is 0.
